ram_slot_arbiter: RTL and testbench

- Shares one single-port 8-bit synchronous RAM among three requesters:
  - the Z80 CPU memory port;
  - the HPS download writer (cartridge/ioctl bytes, buffered in a small FIFO);
  - the tape playback reader.
- Sits between T80s/Pla1, the hps_io ioctl bus, the tape block and a merged main/cartridge/tape RAM, replacing separate dual-port RAMs.
- CPU has cycle-exact priority on its clock-enable slots. Background traffic uses idle cycles.
- A starvation guard steals one CPU slot via WAIT_n when background traffic would otherwise wait too long (fast-tape and x8 modes).

---
 rtl/ram_slot_arbiter_if.sv | 27 ++
 rtl/ram_slot_arbiter.sv | 171 +++++++++++++++++
 tb/tb_ram_slot_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_slot_arbiter_if.sv
// RAM port bundle shared between the slot arbiter (master) and the single-port RAM (slave).
// mem_dout has one cycle of read latency.
interface ram_slot_arbiter_if #(
    parameter int AW = 16
);
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic          mem_en;
    logic [7:0]    mem_dout;

    modport master (
        output mem_addr,
        output mem_din,
        output mem_we,
        output mem_en,
        input  mem_dout
    );

    modport slave (
        input  mem_addr,
        input  mem_din,
        input  mem_we,
        input  mem_en,
        output mem_dout
    );
endinterface

// File: rtl/ram_slot_arbiter.sv
// Shares one single-port RAM between the Z80 (priority on its ce slots), a buffered download
// writer and the tape reader; a starvation guard steals one CPU slot via WAIT_n when needed.
module ram_slot_arbiter #(
    parameter int AW           = 16,
    parameter int FIFO_LOG2    = 2,
    parameter int STARVE_LIMIT = 64
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          cpu_ce,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_wait_n,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_full,
    output logic          dl_idle,
    output logic          dl_overflow,
    input  logic          tape_req,
    input  logic [AW-1:0] tape_addr,
    output logic          tape_ack,
    output logic [7:0]    tape_data,
    ram_slot_arbiter_if.master mem
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [FIFO_LOG2:0] FULL_CNT   = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [SW-1:0]      STARVE_MAX = SW'(STARVE_LIMIT);

    logic [AW-1:0]        fifo_addr_q [DEPTH];
    logic [AW-1:0]        fifo_addr_d [DEPTH];
    logic [7:0]           fifo_data_q [DEPTH];
    logic [7:0]           fifo_data_d [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2:0]   count_q, count_d;
    logic                 rr_q, rr_d;
    logic                 inflight_q, inflight_d;
    logic                 tape_ack_q, tape_ack_d;
    logic [7:0]           tape_data_q, tape_data_d;
    logic [SW-1:0]        starve_q, starve_d;
    logic                 steal_q, steal_d;
    logic                 overflow_q, overflow_d;

    logic fifo_pend, tape_pend, bg_pend, both_pend;
    logic cpu_grant, bg_grant, pick_tape, fifo_grant, tape_grant;
    logic push, pop;

    // Grant decision: CPU on its ce slot unless a steal is armed, else background winner.
    always_comb begin
        fifo_pend  = (count_q != '0);
        tape_pend  = tape_req & ~inflight_q & ~tape_ack_q;
        bg_pend    = fifo_pend | tape_pend;
        both_pend  = fifo_pend & tape_pend;
        cpu_grant  = cpu_ce & cpu_req & ~steal_q;
        bg_grant   = ~cpu_grant & bg_pend;
        pick_tape  = tape_pend & (~fifo_pend | rr_q);
        fifo_grant = bg_grant & ~pick_tape;
        tape_grant = bg_grant & pick_tape;
        pop        = fifo_grant;
        push       = dl_wr & ((count_q != FULL_CNT) | pop);
    end

    always_comb begin
        mem.mem_en   = 1'b0;
        mem.mem_we   = 1'b0;
        mem.mem_addr = cpu_addr;
        mem.mem_din  = 8'h00;
        if (cpu_grant) begin
            mem.mem_en  = 1'b1;
            mem.mem_we  = cpu_we;
            mem.mem_din = cpu_din;
        end else if (fifo_grant) begin
            mem.mem_en   = 1'b1;
            mem.mem_we   = 1'b1;
            mem.mem_addr = fifo_addr_q[rd_ptr_q];
            mem.mem_din  = fifo_data_q[rd_ptr_q];
        end else if (tape_grant) begin
            mem.mem_en   = 1'b1;
            mem.mem_addr = tape_addr;
        end
    end

    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = dl_addr;
            fifo_data_d[wr_ptr_q] = dl_data;
            wr_ptr_d              = wr_ptr_q + FIFO_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_LOG2'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (FIFO_LOG2 + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (FIFO_LOG2 + 1)'(1);
        end
        overflow_d = overflow_q | (dl_wr & ~push);
    end

    always_comb begin
        rr_d        = (bg_grant & both_pend) ? ~rr_q : rr_q;
        inflight_d  = tape_grant;
        tape_ack_d  = inflight_q;
        tape_data_d = inflight_q ? mem.mem_dout : tape_data_q;

        starve_d = starve_q;
        if (bg_grant || !bg_pend) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end

        // An armed steal is consumed by the next CPU ce slot, which goes to the background.
        steal_d = steal_q;
        if (steal_q && cpu_ce) begin
            steal_d = 1'b0;
        end else if (starve_q == STARVE_MAX) begin
            steal_d = 1'b1;
        end
    end

    // Entry storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_sys) begin
        fifo_addr_q <= fifo_addr_d;
        fifo_data_q <= fifo_data_d;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rr_q        <= 1'b0;
            inflight_q  <= 1'b0;
            tape_ack_q  <= 1'b0;
            tape_data_q <= 8'h00;
            starve_q    <= '0;
            steal_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rr_q        <= rr_d;
            inflight_q  <= inflight_d;
            tape_ack_q  <= tape_ack_d;
            tape_data_q <= tape_data_d;
            starve_q    <= starve_d;
            steal_q     <= steal_d;
            overflow_q  <= overflow_d;
        end
    end

    assign cpu_dout    = mem.mem_dout;
    assign cpu_wait_n  = ~steal_q;
    assign dl_full     = (count_q == FULL_CNT);
    assign dl_idle     = (count_q == '0) & ~dl_wr;
    assign dl_overflow = overflow_q;
    assign tape_ack    = tape_ack_q;
    assign tape_data   = tape_data_q;
endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Directed bench for ram_slot_arbiter with a behavioural single-port RAM (1-cycle read latency).
module tb_ram_slot_arbiter;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        cpu_ce, cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din, cpu_dout;
    logic        cpu_wait_n;
    logic        dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_full, dl_idle, dl_overflow;
    logic        tape_req;
    logic [15:0] tape_addr;
    logic        tape_ack;
    logic [7:0]  tape_data;

    logic        pre_we;
    logic [15:0] pre_addr;
    logic [7:0]  pre_data;
    logic [7:0]  ram [0:65535];
    int          wr_cnt = 0;
    int          n_cmp  = 0;
    int          n_bad  = 0;

    always #5 clk_sys = ~clk_sys;

    ram_slot_arbiter_if #(.AW(16)) mem_if ();

    ram_slot_arbiter #(.AW(16), .FIFO_LOG2(2), .STARVE_LIMIT(64)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .cpu_ce      (cpu_ce),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .cpu_wait_n  (cpu_wait_n),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .dl_full     (dl_full),
        .dl_idle     (dl_idle),
        .dl_overflow (dl_overflow),
        .tape_req    (tape_req),
        .tape_addr   (tape_addr),
        .tape_ack    (tape_ack),
        .tape_data   (tape_data),
        .mem         (mem_if)
    );

    // RAM model; the preload port lets the bench seed contents without a second driver.
    always @(posedge clk_sys) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_if.mem_en && mem_if.mem_we) begin
            ram[mem_if.mem_addr] <= mem_if.mem_din;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_if.mem_en) mem_if.mem_dout <= ram[mem_if.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_ce = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_din = 8'h00;
        dl_wr = 1'b0; dl_addr = 16'h0000; dl_data = 8'h00;
        tape_req = 1'b0; tape_addr = 16'h0000;
    endtask

    task automatic cpu_busy_read();
        cpu_ce = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        cyc();
        pre_we = 1'b0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    logic [7:0]  pat;
    logic [15:0] a;
    int          base;

    initial begin
        idle_inputs();
        pre_we = 1'b0; pre_addr = 16'h0000; pre_data = 8'h00;
        reset_n = 1'b0;
        cyc();
        preload(16'h0100, 8'hA5);
        preload(16'h0200, 8'h5C);
        preload(16'hF001, 8'hEE);
        preload(16'hF002, 8'hEE);
        chk("rst_tape_ack", 32'(tape_ack), 0);
        chk("rst_tape_data", 32'(tape_data), 0);
        chk("rst_wait_n", 32'(cpu_wait_n), 1);
        chk("rst_dl_full", 32'(dl_full), 0);
        chk("rst_dl_idle", 32'(dl_idle), 1);
        chk("rst_overflow", 32'(dl_overflow), 0);
        chk("rst_mem_en", 32'(mem_if.mem_en), 0);
        reset_n = 1'b1;

        // Download with idle CPU: one write per cycle, drained in order.
        for (int i = 0; i < 4; i++) begin
            cyc();
            dl_wr = 1'b1; dl_addr = 16'hC000 + 16'(i); dl_data = 8'h11 * 8'(i + 1);
            #1 chk("dl_full_low", 32'(dl_full), 0);
        end
        cyc();
        dl_wr = 1'b0;
        #1 chk("dl_idle_draining", 32'(dl_idle), 0);
        cyc();
        chk("dl_idle_back", 32'(dl_idle), 1);
        for (int i = 0; i < 4; i++) begin
            a = 16'hC000 + 16'(i);
            chk("dl_ram", 32'(ram[a]), 32'h11 * 32'(i + 1));
        end

        // Tape read with idle CPU.
        cyc();
        tape_req = 1'b1; tape_addr = 16'h0100;
        #1;
        chk("tape_issue_en", 32'(mem_if.mem_en), 1);
        chk("tape_issue_we", 32'(mem_if.mem_we), 0);
        chk("tape_issue_addr", 32'(mem_if.mem_addr), 32'h0100);
        cyc();
        chk("tape_inflight_ack", 32'(tape_ack), 0);
        chk("tape_inflight_en", 32'(mem_if.mem_en), 0);
        cyc();
        chk("tape_ack", 32'(tape_ack), 1);
        chk("tape_data", 32'(tape_data), 32'hA5);
        chk("tape_ack_no_issue", 32'(mem_if.mem_en), 0);
        tape_req = 1'b0;
        cyc();
        chk("tape_ack_pulse", 32'(tape_ack), 0);

        // CPU busy every cycle: overflow, then one stolen slot after the starvation limit.
        reset_dut();
        base = wr_cnt;
        for (int k = 0; k < 71; k++) begin
            cyc();
            cpu_busy_read();
            dl_wr = (k < 5); dl_addr = 16'hE000 + 16'(k); dl_data = 8'hE0 + 8'(k);
            #1;
            if (k == 5) begin
                chk("ovf_sticky", 32'(dl_overflow), 1);
                chk("ovf_full", 32'(dl_full), 1);
            end
            if (k == 65) chk("steal_not_yet", 32'(cpu_wait_n), 1);
            if (k == 66) begin
                chk("steal_wait_n", 32'(cpu_wait_n), 0);
                chk("steal_we", 32'(mem_if.mem_we), 1);
                chk("steal_addr", 32'(mem_if.mem_addr), 32'hE000);
            end
            if (k == 67) chk("steal_release", 32'(cpu_wait_n), 1);
        end
        chk("steal_one_write", 32'(wr_cnt - base), 1);
        idle_inputs();
        for (int i = 0; i < 5; i++) cyc();
        for (int i = 0; i < 4; i++) begin
            a = 16'hE000 + 16'(i);
            chk("steal_ram", 32'(ram[a]), 32'hE0 + 32'(i));
        end
        chk("ovf_kept", 32'(dl_overflow), 1);

        // Contested background: FIFO kept full, tape held; pattern F T F F F T F F.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            cyc();
            cpu_busy_read();
            dl_wr = 1'b1; dl_addr = 16'hD000 + 16'(i); dl_data = 8'(i);
        end
        pat = 8'b1101_1101;
        for (int j = 0; j < 8; j++) begin
            cyc();
            cpu_ce = 1'b0; cpu_req = 1'b0;
            tape_req = 1'b1; tape_addr = 16'h0200;
            dl_wr = 1'b1; dl_addr = 16'hD100 + 16'(j); dl_data = 8'(j);
            #1;
            chk("rr_en", 32'(mem_if.mem_en), 1);
            chk("rr_we", 32'(mem_if.mem_we), 32'(pat[j]));
            if (j == 1 || j == 5) chk("rr_tape_addr", 32'(mem_if.mem_addr), 32'h0200);
            if (j == 3) chk("rr_tape_data", 32'(tape_data), 32'h5C);
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) cyc();

        // CPU write and same-cycle download to one address: download lands last.
        reset_dut();
        cyc();
        cpu_ce = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_din = 8'h5A;
        dl_wr = 1'b1; dl_addr = 16'h4000; dl_data = 8'h77;
        #1;
        chk("col_cpu_we", 32'(mem_if.mem_we), 1);
        chk("col_cpu_din", 32'(mem_if.mem_din), 32'h5A);
        cyc();
        cpu_ce = 1'b0; dl_wr = 1'b0;
        #1;
        chk("col_fifo_we", 32'(mem_if.mem_we), 1);
        chk("col_fifo_addr", 32'(mem_if.mem_addr), 32'h4000);
        chk("col_fifo_din", 32'(mem_if.mem_din), 32'h77);
        cyc();
        idle_inputs();
        #1 chk("col_ram", 32'(ram[16'h4000]), 32'h77);
        cyc();
        cpu_ce = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hC002;
        #1 chk("cpu_rd_en", 32'(mem_if.mem_en), 1);
        cyc();
        cpu_ce = 1'b0;
        #1 chk("cpu_dout", 32'(cpu_dout), 32'h33);

        // Reset with two queued entries and a tape read in flight.
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            cyc();
            cpu_busy_read();
            dl_wr = 1'b1; dl_addr = 16'hF000 + 16'(i); dl_data = 8'h90 + 8'(i);
        end
        cyc();
        cpu_ce = 1'b0; cpu_req = 1'b0; dl_wr = 1'b0;
        tape_req = 1'b1; tape_addr = 16'h0100;
        #1 chk("rstf_fifo_first", 32'(mem_if.mem_we), 1);
        cyc();
        chk("rstf_tape_addr", 32'(mem_if.mem_addr), 32'h0100);
        cyc();
        tape_req = 1'b0;
        cpu_busy_read();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        idle_inputs();
        #1;
        chk("rstf_no_ack", 32'(tape_ack), 0);
        chk("rstf_tape_data", 32'(tape_data), 0);
        chk("rstf_dl_idle", 32'(dl_idle), 1);
        chk("rstf_wait_n", 32'(cpu_wait_n), 1);
        chk("rstf_dl_full", 32'(dl_full), 0);
        for (int i = 0; i < 3; i++) cyc();
        chk("rstf_ram0", 32'(ram[16'hF000]), 32'h90);
        chk("rstf_ram1", 32'(ram[16'hF001]), 32'hEE);
        chk("rstf_ram2", 32'(ram[16'hF002]), 32'hEE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
